// File: rtl/div_16x8_seq_pkg.sv
// Shared arithmetic package for the 16/8 sequential divider:
// FSM state encoding and operand widths.
package div_16x8_seq_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_16x8_seq_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, emit the quotient bit.
module div_step_16x8
    import div_16x8_seq_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;

    assign shifted = {rem_in, dvd_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});

    // After a successful subtract the result is below the divisor, so it fits.
    assign rem_out = q_bit ? DIVISOR_W'(shifted - {1'b0, divisor})
                           : shifted[DIVISOR_W-1:0];

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring radix-2 divider, 16-bit dividend by 8-bit divisor,
// one quotient bit per clock with valid/ready handshakes on both sides.
module div_16x8_seq
    import div_16x8_seq_pkg::*;
#(
    parameter int TRUNC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] Q,
    output logic [DIVISOR_W-1:0]  REM,
    output logic                  DZ
);

    localparam int N = DIVIDEND_W - TRUNC;
    localparam logic [4:0] LAST = 5'(N - 1);

    if (TRUNC < 0 || TRUNC > 8) begin : g_bad_trunc
        $error("div_16x8_seq: TRUNC must be in 0..8");
    end

    state_t                  state;
    logic [DIVIDEND_W-1:0]   a_sh;
    logic [DIVIDEND_W-2:0]   q_acc;
    logic [DIVISOR_W-1:0]    b_reg;
    logic [DIVISOR_W-1:0]    prem;
    logic [4:0]              cnt;
    logic [DIVISOR_W-1:0]    prem_next;
    logic                    q_bit;
    logic [DIVIDEND_W-1:0]   q_final;

    div_step_16x8 u_step (
        .rem_in  (prem),
        .dvd_bit (a_sh[DIVIDEND_W-1]),
        .divisor (b_reg),
        .rem_out (prem_next),
        .q_bit   (q_bit)
    );

    assign in_ready = (state == IDLE) && !rst;
    // Only N quotient bits are produced; the truncated low bits read as zero.
    assign q_final  = {q_acc, q_bit} << TRUNC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Q         <= '0;
            REM       <= '0;
            DZ        <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            q_acc     <= '0;
            b_reg     <= '0;
            prem      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        b_reg <= B;
                        prem  <= '0;
                        q_acc <= '0;
                        cnt   <= '0;
                        if (B == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            Q         <= '1;
                            REM       <= A[DIVISOR_W-1:0];
                            DZ        <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= prem_next;
                    a_sh  <= {a_sh[DIVIDEND_W-2:0], 1'b0};
                    q_acc <= {q_acc[DIVIDEND_W-3:0], q_bit};
                    cnt   <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Q         <= q_final;
                        REM       <= prem_next;
                        DZ        <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
